// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light phase sequencer, the dot-matrix
// renderer and the seven-segment decoder.
package traffic_pkg;

    // Width of the seconds-remaining countdown (holds 1..9).
    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } phase_t;

    // One-hot light encodings: [2]=green, [1]=yellow, [0]=red.
    localparam logic [2:0] GYR_GREEN  = 3'b100;
    localparam logic [2:0] GYR_YELLOW = 3'b010;
    localparam logic [2:0] GYR_RED    = 3'b001;

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: free-running modulo-TICK_DIV counter that freezes
// while hold is high and flags the last cycle of each second.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    output logic tick
);

    localparam int         W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] pre;

    // Advance and wrap the prescaler unless frozen by hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre <= '0;
        end else if (!hold) begin
            pre <= (pre == LAST) ? '0 : pre + 1'b1;
        end
    end

    assign tick = (pre == LAST) && !hold;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Green/yellow/red phase sequencer with per-phase seconds countdown and a
// pedestrian request latch that shortens the remaining green time.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int GREEN_SEC  = 9,
    parameter int YELLOW_SEC = 3,
    parameter int RED_SEC    = 9,
    parameter int PED_SEC    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ped_req,
    input  logic               hold,
    output logic [2:0]         gyr,
    output logic [COUNT_W-1:0] count,
    output logic               phase_start,
    output logic               ped_wait
);

    localparam logic [COUNT_W-1:0] GREEN_CNT  = COUNT_W'(GREEN_SEC);
    localparam logic [COUNT_W-1:0] YELLOW_CNT = COUNT_W'(YELLOW_SEC);
    localparam logic [COUNT_W-1:0] RED_CNT    = COUNT_W'(RED_SEC);
    localparam logic [COUNT_W-1:0] PED_CNT    = COUNT_W'(PED_SEC);

    phase_t             state;
    phase_t             next_state;
    logic [2:0]         next_gyr;
    logic [COUNT_W-1:0] next_dur;
    logic               tick;
    logic               shorten;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .hold  (hold),
        .tick  (tick)
    );

    // Successor phase together with its light pattern and duration.
    always_comb begin
        next_state = GREEN;
        next_gyr   = GYR_GREEN;
        next_dur   = GREEN_CNT;
        case (state)
            GREEN: begin
                next_state = YELLOW;
                next_gyr   = GYR_YELLOW;
                next_dur   = YELLOW_CNT;
            end
            YELLOW: begin
                next_state = RED;
                next_gyr   = GYR_RED;
                next_dur   = RED_CNT;
            end
            default: begin
                next_state = GREEN;
                next_gyr   = GYR_GREEN;
                next_dur   = GREEN_CNT;
            end
        endcase
    end

    // Pending request cuts green to PED_SEC; only fires while count is above it.
    assign shorten = (state == GREEN) && ped_wait && (count > PED_CNT);

    // Phase FSM, countdown and pedestrian latch; all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= GREEN;
            gyr         <= GYR_GREEN;
            count       <= GREEN_CNT;
            phase_start <= 1'b0;
            ped_wait    <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            if (ped_req && (state != RED)) begin
                ped_wait <= 1'b1;
            end
            if (shorten) begin
                count <= PED_CNT;
            end else if (tick) begin
                if (count > COUNT_W'(1)) begin
                    count <= count - 1'b1;
                end else begin
                    state       <= next_state;
                    gyr         <= next_gyr;
                    count       <= next_dur;
                    phase_start <= 1'b1;
                    // Entering red serves the request; overrides a same-cycle set.
                    if (next_state == RED) begin
                        ped_wait <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer: table of timed vectors,
// hand-written corner sequences, then randomized stimulus against a model.
module tb_traffic_phase_sequencer;

    localparam int TD = 4;
    localparam int GS = 5;
    localparam int YS = 2;
    localparam int RS = 4;
    localparam int PS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ped_req = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] gyr;
    logic [3:0] count;
    logic       phase_start;
    logic       ped_wait;

    always #5 clock = ~clock;

    traffic_phase_sequencer #(
        .TICK_DIV   (TD),
        .GREEN_SEC  (GS),
        .YELLOW_SEC (YS),
        .RED_SEC    (RS),
        .PED_SEC    (PS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ped_req     (ped_req),
        .hold        (hold),
        .gyr         (gyr),
        .count       (count),
        .phase_start (phase_start),
        .ped_wait    (ped_wait)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase index 0/1/2 = green/yellow/red, seconds left,
    // position within the current second, pending request, phase-start flag.
    int dur [3] = '{GS, YS, RS};
    int m_phase = 0;
    int m_secs  = GS;
    int m_sub   = 0;
    bit m_wait  = 1'b0;
    bit m_start = 1'b0;

    typedef struct {
        int         n;
        bit         rst;
        bit         ped;
        bit         hld;
        logic [2:0] gyr;
        int         cnt;
        bit         ps;
        bit         w;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs seen at this edge.
    task automatic model_edge();
        bit second_done;
        int phase_n;
        int secs_n;
        bit wait_n;
        bit start_n;
        if (reset) begin
            m_phase = 0;
            m_secs  = GS;
            m_sub   = 0;
            m_wait  = 1'b0;
            m_start = 1'b0;
        end else begin
            second_done = (m_sub == TD - 1) && !hold;
            phase_n = m_phase;
            secs_n  = m_secs;
            start_n = 1'b0;
            wait_n  = m_wait || (ped_req && m_phase != 2);
            if (m_phase == 0 && m_wait && m_secs > PS) begin
                secs_n = PS;
            end else if (second_done) begin
                if (m_secs > 1) begin
                    secs_n = m_secs - 1;
                end else begin
                    phase_n = (m_phase + 1) % 3;
                    secs_n  = dur[phase_n];
                    start_n = 1'b1;
                    if (phase_n == 2) wait_n = 1'b0;
                end
            end
            if (!hold) m_sub = (m_sub + 1) % TD;
            m_phase = phase_n;
            m_secs  = secs_n;
            m_wait  = wait_n;
            m_start = start_n;
        end
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic step();
        logic [2:0] exp_gyr;
        @(posedge clock);
        model_edge();
        #1;
        exp_gyr = 3'b100 >> m_phase;
        chk("model_gyr", int'(gyr), int'(exp_gyr));
        chk("model_count", int'(count), m_secs);
        chk("model_phase_start", int'(phase_start), int'(m_start));
        chk("model_ped_wait", int'(ped_wait), int'(m_wait));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_out(input string tag, input logic [2:0] g, input int c,
                              input bit ps, input bit w);
        chk({tag, "_gyr"}, int'(gyr), int'(g));
        chk({tag, "_count"}, int'(count), c);
        chk({tag, "_phase_start"}, int'(phase_start), int'(ps));
        chk({tag, "_ped_wait"}, int'(ped_wait), int'(w));
    endtask

    initial begin
        // Free-run sequence followed by an early pedestrian shortening.
        tbl.push_back('{1,  1'b1, 1'b0, 1'b0, 3'b100, 5, 1'b0, 1'b0});
        tbl.push_back('{4,  1'b0, 1'b0, 1'b0, 3'b100, 4, 1'b0, 1'b0});
        tbl.push_back('{15, 1'b0, 1'b0, 1'b0, 3'b100, 1, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 3'b010, 2, 1'b1, 1'b0});
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 3'b010, 2, 1'b0, 1'b0});
        tbl.push_back('{7,  1'b0, 1'b0, 1'b0, 3'b001, 4, 1'b1, 1'b0});
        tbl.push_back('{16, 1'b0, 1'b0, 1'b0, 3'b100, 5, 1'b1, 1'b0});
        tbl.push_back('{1,  1'b0, 1'b1, 1'b0, 3'b100, 5, 1'b0, 1'b1});
        tbl.push_back('{1,  1'b0, 1'b0, 1'b0, 3'b100, 2, 1'b0, 1'b1});
        tbl.push_back('{2,  1'b0, 1'b0, 1'b0, 3'b100, 1, 1'b0, 1'b1});
        tbl.push_back('{4,  1'b0, 1'b0, 1'b0, 3'b010, 2, 1'b1, 1'b1});
        tbl.push_back('{8,  1'b0, 1'b0, 1'b0, 3'b001, 4, 1'b1, 1'b0});
        tbl.push_back('{16, 1'b0, 1'b0, 1'b0, 3'b100, 5, 1'b1, 1'b0});

        foreach (tbl[i]) begin
            reset   = tbl[i].rst;
            ped_req = tbl[i].ped;
            hold    = tbl[i].hld;
            run(tbl[i].n);
            reset   = 1'b0;
            ped_req = 1'b0;
            hold    = 1'b0;
            expect_out($sformatf("vec%0d", i), tbl[i].gyr, tbl[i].cnt, tbl[i].ps, tbl[i].w);
        end

        // Late request at count 1: no shortening, held through yellow.
        run(16);
        expect_out("late_pre", 3'b100, 1, 1'b0, 1'b0);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        expect_out("late_latch", 3'b100, 1, 1'b0, 1'b1);
        run(3);
        expect_out("late_yellow", 3'b010, 2, 1'b1, 1'b1);
        run(8);
        expect_out("late_red", 3'b001, 4, 1'b1, 1'b0);

        // Hold mid-green at count 3 with the prescaler two cycles into a second.
        run(16);
        expect_out("hold_green", 3'b100, 5, 1'b1, 1'b0);
        run(10);
        expect_out("hold_pre", 3'b100, 3, 1'b0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_count", int'(count), 3);
            chk("hold_phase_start", int'(phase_start), 0);
        end
        hold = 1'b0;
        step();
        expect_out("hold_resume1", 3'b100, 3, 1'b0, 1'b0);
        step();
        expect_out("hold_resume2", 3'b100, 2, 1'b0, 1'b0);
        run(8);
        expect_out("hold_yellow", 3'b010, 2, 1'b1, 1'b0);
        run(8);
        expect_out("hold_red", 3'b001, 4, 1'b1, 1'b0);

        // Request held through the whole of red is ignored.
        ped_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("red_ignore_wait", int'(ped_wait), 0);
        end
        ped_req = 1'b0;
        step();
        expect_out("red_next_green", 3'b100, 5, 1'b1, 1'b0);

        // Reset in yellow with a pending request.
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step();
        expect_out("rst_short", 3'b100, 2, 1'b0, 1'b1);
        run(6);
        expect_out("rst_yellow", 3'b010, 2, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_out("rst_mid", 3'b100, 5, 1'b0, 1'b0);
        step();
        expect_out("rst_after", 3'b100, 5, 1'b0, 1'b0);

        // Randomized stimulus, compared against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            ped_req = ($urandom_range(0, 7) == 0);
            hold    = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
